// File: rtl/stream_pkg.sv
// Shared stream parameters.
//   STREAM_DEPTH : default number of delay-line slots
//   STREAM_BITS  : default data word width
package stream_pkg;

    localparam int unsigned STREAM_DEPTH = 8;
    localparam int unsigned STREAM_BITS  = 64;

endpackage

// File: rtl/fifo_delay_line.sv
// DEPTH x BITS shift register. When en is high every slot moves up one position,
// d enters slot 0 and slot DEPTH-1 falls off the end.
//   clk : clock
//   rst : asynchronous active-high reset, clears every slot
//   en  : shift enable
//   d   : word entering slot 0
//   q   : all slots, slot i at q[i*BITS +: BITS]
module fifo_delay_line
    import stream_pkg::*;
#(
    parameter int unsigned DEPTH = STREAM_DEPTH,
    parameter int unsigned BITS  = STREAM_BITS
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  en,
    input  logic [BITS-1:0]       d,
    output logic [DEPTH*BITS-1:0] q
);

    logic [DEPTH*BITS-1:0] slots_q, slots_d;

    always_comb begin
        slots_d = slots_q;
        if (en) begin
            slots_d = {slots_q[(DEPTH-1)*BITS-1:0], d};
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slots_q <= '0;
        end else begin
            slots_q <= slots_d;
        end
    end

    assign q = slots_q;

endmodule

// File: rtl/fifo_stream_ctrl.sv
// Valid/ready stream buffer built on a shift delay line. A valid-tag vector shifts
// in lockstep with the data; the oldest slot drives the output side.
//   clk, rst  : clock, asynchronous active-high reset
//   flush     : synchronous clear of all valid tags (data slots untouched)
//   in_valid / in_ready / in_data    : producer handshake
//   out_valid / out_ready / out_data : consumer handshake, data from the last slot
//   count     : registered number of live words
module fifo_stream_ctrl
    import stream_pkg::*;
#(
    parameter int unsigned DEPTH = STREAM_DEPTH,
    parameter int unsigned BITS  = STREAM_BITS
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       flush,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [BITS-1:0]            in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [BITS-1:0]            out_data,
    output logic [$clog2(DEPTH+1)-1:0] count
);

    localparam int unsigned CntW = $clog2(DEPTH+1);

    logic [DEPTH-1:0]      vtag_q, vtag_d;
    logic [CntW-1:0]       count_q, count_d;
    logic [DEPTH*BITS-1:0] slots;
    logic                  in_fire, out_fire, shift_en, line_en;
    logic [BITS-1:0]       line_d;

    assign out_valid = vtag_q[DEPTH-1];
    assign out_data  = slots[(DEPTH-1)*BITS +: BITS];
    // Held low during reset so nothing is offered acceptance while state is cleared.
    assign in_ready  = (!vtag_q[DEPTH-1] | out_ready) & !flush & !rst;
    assign in_fire   = in_valid & in_ready;
    assign out_fire  = out_valid & out_ready;
    // Also shift while the head slot is empty but words remain, so they advance.
    assign shift_en  = in_fire | out_fire | (!vtag_q[DEPTH-1] & (|vtag_q));
    assign line_en   = shift_en & !flush;
    assign line_d    = in_fire ? in_data : '0;

    always_comb begin
        vtag_d = vtag_q;
        if (flush) begin
            vtag_d = '0;
        end else if (shift_en) begin
            vtag_d = {vtag_q[DEPTH-2:0], in_fire};
        end
    end

    always_comb begin
        count_d = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            count_d = count_d + CntW'(vtag_d[i]);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vtag_q  <= '0;
            count_q <= '0;
        end else begin
            vtag_q  <= vtag_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;

    fifo_delay_line #(
        .DEPTH (DEPTH),
        .BITS  (BITS)
    ) u_delay_line (
        .clk (clk),
        .rst (rst),
        .en  (line_en),
        .d   (line_d),
        .q   (slots)
    );

endmodule

// File: tb/tb_fifo_stream_ctrl.sv
module tb_fifo_stream_ctrl;

    localparam int unsigned DEPTH = 8;
    localparam int unsigned BITS  = 64;
    localparam logic [63:0] SW_WORD = 64'hDEAD_BEEF_0000_0001;
    localparam int TOTAL_POPS = 27;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            flush = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [BITS-1:0] in_data = '0;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [BITS-1:0] out_data;
    logic [3:0]      count;

    int checks = 0;
    int failures = 0;
    int pops = 0;
    logic [63:0] exp_q[$];

    fifo_stream_ctrl #(
        .DEPTH (DEPTH),
        .BITS  (BITS)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .count     (count)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Inputs change 1 time unit after the rising edge, outputs checked there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard monitor: samples handshakes on the falling edge.
    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
        end else begin
            if (out_valid && out_ready) begin
                checks++;
                if (exp_q.size() == 0) begin
                    failures++;
                    $display("FAIL sb_unexpected: got %h expected none at %0t", out_data, $time);
                end else begin
                    logic [63:0] e;
                    checks--;
                    e = exp_q.pop_front();
                    check("sb_data", out_data, e);
                end
                pops++;
            end
            if (flush) begin
                exp_q.delete();
            end else if (in_valid && in_ready) begin
                exp_q.push_back(in_data);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic single_word();
        out_ready = 1'b1;
        in_valid  = 1'b1;
        in_data   = SW_WORD;
        tick();
        in_valid = 1'b0;
        in_data  = '0;
        check("sw_count_e0", count, 1);
        check("sw_valid_e0", out_valid, 0);
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("sw_count", count, 1);
            check("sw_valid", out_valid, (k == 7));
        end
        check("sw_data", out_data, SW_WORD);
        tick();
        check("sw_count_after", count, 0);
        check("sw_valid_after", out_valid, 0);
    endtask

    initial begin
        // Reset and idle
        tick();
        check("rst_valid", out_valid, 0);
        check("rst_count", count, 0);
        check("rst_ready", in_ready, 0);
        check("rst_data", out_data, 0);
        rst = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            check("idle_valid", out_valid, 0);
            check("idle_count", count, 0);
            check("idle_ready", in_ready, 1);
        end

        // Single word latency
        single_word();

        // Back-to-back stream 1..16
        out_ready = 1'b1;
        for (int i = 1; i <= 16; i++) begin
            in_valid = 1'b1;
            in_data  = 64'(i);
            check("bb_ready", in_ready, 1);
            tick();
            check("bb_valid", out_valid, (i >= 8));
            if (i >= 8) check("bb_data", out_data, 64'(i - 7));
        end
        in_valid = 1'b0;
        for (int j = 1; j <= 8; j++) begin
            tick();
            check("bb_drain_valid", out_valid, (j <= 7));
            if (j <= 7) check("bb_drain_data", out_data, 64'(9 + j));
        end

        // Fill with consumer stalled, then drain
        out_ready = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            in_valid = 1'b1;
            in_data  = 64'h100 + 64'(i);
            check("fill_ready", in_ready, 1);
            tick();
        end
        in_data = 64'hBAD;
        check("full_ready", in_ready, 0);
        check("full_count", count, 8);
        check("full_valid", out_valid, 1);
        check("full_data", out_data, 64'h101);
        for (int k = 0; k < 3; k++) begin
            tick();
            check("stall_count", count, 8);
            check("stall_data", out_data, 64'h101);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        for (int j = 1; j <= 8; j++) begin
            tick();
            check("drain_count", count, 64'(8 - j));
            check("drain_valid", out_valid, (j < 8));
            if (j < 8) check("drain_data", out_data, 64'h101 + 64'(j));
        end

        // Flush with five live words
        for (int i = 1; i <= 5; i++) begin
            in_valid = 1'b1;
            in_data  = 64'h200 + 64'(i);
            tick();
        end
        in_valid = 1'b0;
        check("pre_flush_count", count, 5);
        flush    = 1'b1;
        in_valid = 1'b1;
        in_data  = 64'hBAD;
        #1;
        check("flush_ready", in_ready, 0);
        tick();
        flush    = 1'b0;
        in_valid = 1'b0;
        check("flush_count", count, 0);
        check("flush_valid", out_valid, 0);
        for (int k = 0; k < 8; k++) begin
            tick();
            check("post_flush_valid", out_valid, 0);
        end
        in_valid = 1'b1;
        in_data  = 64'h300;
        tick();
        in_valid = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            tick();
            check("pf_valid", out_valid, (k == 7));
        end
        check("pf_data", out_data, 64'h300);
        tick();
        check("pf_count_after", count, 0);

        // Asynchronous reset mid-stream
        for (int i = 1; i <= 4; i++) begin
            in_valid = 1'b1;
            in_data  = 64'h400 + 64'(i);
            tick();
        end
        in_valid = 1'b0;
        check("pre_rst_count", count, 4);
        #2;
        rst = 1'b1;
        #1;
        check("arst_valid", out_valid, 0);
        check("arst_count", count, 0);
        check("arst_ready", in_ready, 0);
        check("arst_data", out_data, 0);
        tick();
        tick();
        rst = 1'b0;
        single_word();

        repeat (3) tick();
        check("sb_leftover", 64'(exp_q.size()), 0);
        check("sb_pops", 64'(pops), 64'(TOTAL_POPS));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/fifo_stream_ctrl.md
FIFO_STREAM_CTRL -- requirements
Module: fifo_stream_ctrl

Interface
REQ-001 Parameter DEPTH, default 8: number of delay-line slots, minimum 2.
REQ-002 Parameter BITS, default 64: data word width.
REQ-003 clk  input  1  sole clock; all state updates on posedge.
REQ-004 rst  input  1  asynchronous, active-high reset.
REQ-005 flush  input  1  synchronous clear of all valid tags.
REQ-006 in_valid  input  1  producer offers in_data.
REQ-007 in_ready  output  1  block accepts in_data this cycle.
REQ-008 in_data  input  BITS  producer word.
REQ-009 out_valid  output  1  out_data holds the oldest live word.
REQ-010 out_ready  input  1  consumer takes out_data this cycle.
REQ-011 out_data  output  BITS  word in the last (oldest) slot.
REQ-012 count  output  $clog2(DEPTH+1)  number of live words in the delay line.

Function
REQ-013 Block SHALL wrap a DEPTH x BITS shift delay line with a DEPTH-bit valid-tag vector (vtag) that shifts in lockstep with the data.
REQ-014 Definitions: in_fire = in_valid & in_ready; out_fire = out_valid & out_ready.
REQ-015 out_valid SHALL equal vtag[DEPTH-1]; out_data SHALL equal the data slot DEPTH-1, combinationally.
REQ-016 in_ready SHALL equal (!vtag[DEPTH-1] | out_ready) & !flush.
REQ-017 Shift enable SHALL assert when in_fire, or out_fire, or (!vtag[DEPTH-1] & |vtag).
REQ-018 On shift: data slot 0 <- in_data if in_fire else 0; vtag[0] <- in_fire; every slot i moves to i+1; slot DEPTH-1 is discarded.
REQ-019 When vtag[DEPTH-1]=1 and out_ready=0, nothing SHALL shift: in_ready low, all slots hold.
REQ-020 Latency: with no stall, a word accepted at edge k SHALL present out_valid=1 after edge k+DEPTH-1, for example 7 cycles at DEPTH=8.
REQ-021 Words SHALL leave in acceptance order, with no loss and no duplication.
REQ-022 count SHALL equal popcount(vtag), registered, updated the same edge as vtag.
REQ-023 Simultaneous in_fire and out_fire SHALL shift once; count is unchanged.
REQ-024 flush=1 SHALL clear vtag to 0 at the next edge and override any in_fire or shift. Data slots are not cleared. out_valid is 0 and count is 0 after that edge.
REQ-025 in_valid or out_ready held high with no partner SHALL NOT corrupt state.

Reset
REQ-026 rst=1 SHALL asynchronously clear vtag, all data slots and count to 0.
REQ-027 During reset: out_valid=0, out_data=0, count=0, in_ready=0.
REQ-028 Reset asserted mid-transfer SHALL discard all in-flight words. After release, the first accepted word follows REQ-020.

Structure
REQ-029 The data delay line SHALL be a sub-module named fifo_delay_line (ports clk, rst, en, d, q-vector). vtag, control and count logic stay in fifo_stream_ctrl.
REQ-030 No package typedefs are required. DEPTH and BITS defaults SHALL come from shared package stream_pkg (STREAM_DEPTH=8, STREAM_BITS=64).

Verification
REQ-031 Reset then idle: out_valid=0, count=0, in_ready=1 every cycle.
REQ-032 Single word 0xDEAD_BEEF_0000_0001 accepted at edge 0 with out_ready=1 -> out_valid first high after edge 7 with that data; count=1 from edge 0 to 7, then 0 after the consume edge.
REQ-033 Back-to-back stream 1..16 with out_ready=1 -> outputs 1..16 in order, one per cycle, starting 7 cycles after the first accept; in_ready never drops.
REQ-034 Fill 8 words with out_ready=0 -> in_ready drops once word 1 reaches the last slot; count=8 held; releasing out_ready drains 1..8 in order, one per cycle.
REQ-035 Assert flush with count=5 -> next edge count=0, out_valid=0; a word accepted afterwards appears 7 cycles later, unaffected.
REQ-036 Assert rst asynchronously mid-stream (count=4) -> out_valid and count drop immediately; after release, behaviour is identical to REQ-032.
